// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with valid/ready handshake, flags, compare, barrel
// left shift and an iterative shift-add multiplier. One operation in flight.
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] R,
  output logic               carry,
  output logic               zero,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [WIDTH-1:0] WMOD = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   shamt;
  logic [2*WIDTH-1:0] shl, op_r;
  logic               op_c;

  logic [2*WIDTH-1:0] acc, mcand, addend, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;

  // Single-cycle operation result, evaluated from the live inputs at accept
  always_comb begin
    op_r  = '0;
    op_c  = 1'b0;
    sum   = {1'b0, A} + {1'b0, B};
    // extending both operands by one bit makes bit WIDTH the borrow
    diff  = {1'b0, A} - {1'b0, B};
    shamt = B % WMOD;
    shl   = {{WIDTH{1'b0}}, A} << shamt;
    case (sel)
      OP_ADD: begin
        op_r = {{(WIDTH-1){1'b0}}, sum};
        op_c = sum[WIDTH];
      end
      OP_SUB: begin
        op_r = {{(WIDTH-1){1'b0}}, diff};
        op_c = diff[WIDTH];
      end
      OP_AND: op_r = {{WIDTH{1'b0}}, A & B};
      OP_OR:  op_r = {{WIDTH{1'b0}}, A | B};
      OP_XOR: op_r = {{WIDTH{1'b0}}, A ^ B};
      OP_CMP: op_r = {{(2*WIDTH-3){1'b0}}, (A > B), (A == B), (A < B)};
      OP_SHL: begin
        op_r = shl;
        op_c = |shl[2*WIDTH-1:WIDTH];
      end
      default: op_r = '0;  // MUL goes through the iterative path
    endcase
  end

  // One shift-add partial product per cycle
  always_comb begin
    addend    = mplier[0] ? mcand : '0;
    acc_nxt   = acc + addend;
    last_iter = (cnt == CNT_W'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = (sel == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (last_iter) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Datapath: capture on accept, iterate in MUL, hold in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      R      <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (sel == OP_MUL) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              cnt    <= CNT_W'(WIDTH);
            end else begin
              R     <= op_r;
              carry <= op_c;
              zero  <= (op_r == '0);
            end
          end
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          // result registers only change on the final step, so a reset
          // mid-multiply never exposes a partial product
          if (last_iter) begin
            R     <= acc_nxt;
            carry <= |acc_nxt[2*WIDTH-1:WIDTH];
            zero  <= (acc_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors and a randomised sweep for alu_seq at
// WIDTH=4 and WIDTH=8, checked through an expected-result queue.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] a4, b4;
  logic [2:0] s4;
  logic       iv4, ir4, c4, z4, ov4, or4;
  logic [7:0] r4;

  logic [7:0]  a8, b8;
  logic [2:0]  s8;
  logic        iv8, ir8, c8, z8, ov8, or8;
  logic [15:0] r8;

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .sel(s4),
    .in_valid(iv4), .in_ready(ir4), .R(r4), .carry(c4), .zero(z4),
    .out_valid(ov4), .out_ready(or4)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .sel(s8),
    .in_valid(iv8), .in_ready(ir8), .R(r8), .carry(c8), .zero(z8),
    .out_valid(ov8), .out_ready(or8)
  );

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        z;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
    logic [7:0] r;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  // 8-bit reference: plain integer arithmetic
  function automatic exp_t model8(input int a, input int b, input int s);
    exp_t e;
    int   r, d;
    r = 0;
    e.c = 1'b0;
    case (s)
      0: begin r = a + b; e.c = (r > 255); end
      1: begin d = a - b; r = (d < 0) ? d + 512 : d; e.c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a > b) ? 4 : (a == b) ? 2 : 1;
      6: begin r = (a << (b % 8)) & 16'hFFFF; e.c = (r > 255); end
      default: begin r = a * b; e.c = (r > 255); end
    endcase
    e.r = r[15:0];
    e.z = (r == 0);
    return e;
  endfunction

  // Issue one op, push its expectation at the accept edge, pop on out_valid
  task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] s, input exp_t e, input int exp_lat);
    int   n;
    exp_t got, want;
    @(negedge clk);
    n = 0;
    while (!(w8 ? ir8 : ir4) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin chk("ready_timeout", 32'd0, 32'd1); return; end
    if (w8) begin a8 = a; b8 = b; s8 = s; iv8 = 1'b1; end
    else begin a4 = a[3:0]; b4 = b[3:0]; s4 = s; iv4 = 1'b1; end
    @(posedge clk);
    sb.push_back(e);
    #1;
    iv4 = 1'b0; iv8 = 1'b0;
    // operands change after accept and must be ignored
    a4 = 4'($urandom); b4 = 4'($urandom); s4 = 3'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 3'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!(w8 ? ov8 : ov4) && n < 100);
    if (!(w8 ? ov8 : ov4)) begin
      chk("valid_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    chk("latency", n, exp_lat);
    want  = sb.pop_front();
    got.r = w8 ? r8 : {8'h00, r4};
    got.c = w8 ? c8 : c4;
    got.z = w8 ? z8 : z4;
    chk("R", got.r, want.r);
    chk("carry", got.c, want.c);
    chk("zero", got.z, want.z);
    if (w8) or8 = 1'b1; else or4 = 1'b1;
    @(posedge clk);
    #1;
    or4 = 1'b0; or8 = 1'b0;
    @(negedge clk);
    chk("valid_drop", w8 ? ov8 : ov4, 1'b0);
    chk("ready_back", w8 ? ir8 : ir4, 1'b1);
  endtask

  vec_t v[16];

  initial begin
    int   seen;
    exp_t e;
    logic [7:0] ra, rb;
    logic [2:0] rs;

    v[0]  = '{4'd8,  4'd8,  3'b000, 8'h10, 1'b1, 1'b0, 1};
    v[1]  = '{4'd2,  4'd5,  3'b001, 8'h1D, 1'b1, 1'b0, 1};
    v[2]  = '{4'd5,  4'd5,  3'b001, 8'h00, 1'b0, 1'b1, 1};
    v[3]  = '{4'd5,  4'd5,  3'b101, 8'h02, 1'b0, 1'b0, 1};
    v[4]  = '{4'd2,  4'd12, 3'b100, 8'h0E, 1'b0, 1'b0, 1};
    v[5]  = '{4'd4,  4'd11, 3'b110, 8'h20, 1'b1, 1'b0, 1};
    v[6]  = '{4'd1,  4'd5,  3'b110, 8'h02, 1'b0, 1'b0, 1};
    v[7]  = '{4'd2,  4'd5,  3'b111, 8'h0A, 1'b0, 1'b0, 5};
    v[8]  = '{4'd15, 4'd15, 3'b111, 8'hE1, 1'b1, 1'b0, 5};
    v[9]  = '{4'd0,  4'd9,  3'b111, 8'h00, 1'b0, 1'b1, 5};
    v[10] = '{4'd12, 4'd10, 3'b010, 8'h08, 1'b0, 1'b0, 1};
    v[11] = '{4'd12, 4'd3,  3'b011, 8'h0F, 1'b0, 1'b0, 1};
    v[12] = '{4'd2,  4'd9,  3'b101, 8'h01, 1'b0, 1'b0, 1};
    v[13] = '{4'd9,  4'd2,  3'b101, 8'h04, 1'b0, 1'b0, 1};
    v[14] = '{4'd15, 4'd15, 3'b000, 8'h1E, 1'b1, 1'b0, 1};
    v[15] = '{4'd0,  4'd0,  3'b000, 8'h00, 1'b0, 1'b1, 1};

    a4 = '0; b4 = '0; s4 = '0; iv4 = 1'b0; or4 = 1'b0;
    a8 = '0; b8 = '0; s8 = '0; iv8 = 1'b0; or8 = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_R", r4, 8'h00);
    chk("rst_carry", c4, 1'b0);
    chk("rst_zero", z4, 1'b0);
    chk("rst_out_valid", ov4, 1'b0);
    chk("rst_in_ready", ir4, 1'b1);
    chk("rst_out_valid8", ov8, 1'b0);
    rst_n = 1'b1;

    // directed table, WIDTH=4
    for (int i = 0; i < 16; i++) begin
      e.r = {8'h00, v[i].r}; e.c = v[i].c; e.z = v[i].z;
      run_op(1'b0, {4'h0, v[i].a}, {4'h0, v[i].b}, v[i].s, e, v[i].lat);
    end

    // backpressure: result held, new request refused until drained
    @(negedge clk);
    a4 = 4'd8; b4 = 4'd8; s4 = 3'b000; iv4 = 1'b1;
    @(posedge clk);
    #1 iv4 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a4 = 4'd3; b4 = 4'd4; s4 = 3'b000; iv4 = 1'b1; end
      chk("bp_R", r4, 8'h10);
      chk("bp_carry", c4, 1'b1);
      chk("bp_zero", z4, 1'b0);
      chk("bp_out_valid", ov4, 1'b1);
      chk("bp_in_ready", ir4, 1'b0);
      @(negedge clk);
    end
    or4 = 1'b1;
    @(posedge clk);
    #1 or4 = 1'b0;
    @(negedge clk);
    chk("bp_release_valid", ov4, 1'b0);
    chk("bp_release_ready", ir4, 1'b1);
    @(posedge clk);
    #1 iv4 = 1'b0;
    @(negedge clk);
    chk("bp_pending_valid", ov4, 1'b1);
    chk("bp_pending_R", r4, 8'h07);
    chk("bp_pending_carry", c4, 1'b0);
    or4 = 1'b1;
    @(posedge clk);
    #1 or4 = 1'b0;

    // reset in the middle of a multiply
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; s4 = 3'b111; iv4 = 1'b1;
    @(posedge clk);
    #1 iv4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_R", r4, 8'h00);
    chk("midrst_carry", c4, 1'b0);
    chk("midrst_zero", z4, 1'b0);
    chk("midrst_out_valid", ov4, 1'b0);
    chk("midrst_in_ready", ir4, 1'b1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (ov4) seen++;
      @(negedge clk);
    end
    chk("midrst_no_pulse", seen, 0);
    e.r = 16'h0007; e.c = 1'b0; e.z = 1'b0;
    run_op(1'b0, 8'd3, 8'd4, 3'b000, e, 1);

    // WIDTH=8 directed
    e.r = 16'hFE01; e.c = 1'b1; e.z = 1'b0;
    run_op(1'b1, 8'd255, 8'd255, 3'b111, e, 9);
    e.r = 16'h012C; e.c = 1'b1; e.z = 1'b0;
    run_op(1'b1, 8'd200, 8'd100, 3'b000, e, 1);

    // WIDTH=8 random sweep
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 3'($urandom_range(0, 7));
      e  = model8(int'(ra), int'(rb), int'(rs));
      run_op(1'b1, ra, rb, rs, e, (rs == 3'b111) ? 9 : 1);
    end

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
